// File: rtl/ha_sub.sv
// ha_sub: registered bank of WIDTH independent 1-bit half subtractors (A-B per lane).
// Latency: 1 cycle from an accepted input (in_valid=1 at a clk edge) to out_valid/diff/borrow.
// Backpressure: none; every cycle with in_valid=1 is accepted, back-to-back in gives back-to-back out.
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset; clears every output and wins over in_valid
//   in_valid    A/B qualify this cycle
//   A, B        minuend / subtrahend, one bit per lane
//   out_valid   diff/borrow hold the result of the input accepted at the last edge
//   diff        per-lane A^B
//   borrow      per-lane ~A&B
//   borrow_any  OR of the borrow lanes, registered from the same sample as borrow
//   borrow_cnt  population count of borrow lanes; exists only when HA_SUB_BORROW_CNT_EN is defined
//
// Optional feature macro: HA_SUB_BORROW_CNT_EN (adds borrow_cnt, width $clog2(WIDTH+1)).

module ha_sub #(
    parameter int WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               A,
    input  logic [WIDTH-1:0]               B,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               diff,
    output logic [WIDTH-1:0]               borrow,
`ifdef HA_SUB_BORROW_CNT_EN
    output logic [$clog2(WIDTH+1)-1:0]     borrow_cnt,
`endif
    output logic                           borrow_any
);

    logic               out_valid_q;
    logic [WIDTH-1:0]   diff_d, diff_q;
    logic [WIDTH-1:0]   borrow_d, borrow_q;
    logic               borrow_any_d, borrow_any_q;

    // Per-lane combinational half subtractor; lanes never interact.
    always_comb begin
        diff_d       = A ^ B;
        borrow_d     = ~A & B;
        borrow_any_d = |borrow_d;
    end

`ifdef HA_SUB_BORROW_CNT_EN
    // WIDTH+1 distinct counts (0..WIDTH) so an all-borrow input never wraps.
    localparam int CW = $clog2(WIDTH+1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + CW'(borrow_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (in_valid) begin
            cnt_q <= cnt_d;
        end
    end

    assign borrow_cnt = cnt_q;
`endif

    // Data registers load only on accepted inputs, so A/B garbage during
    // idle cycles never reaches the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            diff_q       <= '0;
            borrow_q     <= '0;
            borrow_any_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                diff_q       <= diff_d;
                borrow_q     <= borrow_d;
                borrow_any_q <= borrow_any_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow     = borrow_q;
    assign borrow_any = borrow_any_q;

endmodule

// File: tb/tb_ha_sub.sv
// tb_ha_sub: scoreboard bench driving a WIDTH=1 and a WIDTH=8 ha_sub in lockstep.
// Latency: expects each accepted vector one edge later; outputs sampled on the falling edge.
// Backpressure: none exercised; in_valid is shared by both instances.

module tb_ha_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;

    logic       ov1, ov8;
    logic [0:0] d1, br1;
    logic [7:0] d8, br8;
    logic       any1, any8;
`ifdef HA_SUB_BORROW_CNT_EN
    logic [0:0] cnt1;
    logic [3:0] cnt8;
`endif

    always #5 clk = ~clk;

    ha_sub #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a1),
        .B          (b1),
        .out_valid  (ov1),
        .diff       (d1),
        .borrow     (br1),
`ifdef HA_SUB_BORROW_CNT_EN
        .borrow_cnt (cnt1),
`endif
        .borrow_any (any1)
    );

    ha_sub #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a8),
        .B          (b8),
        .out_valid  (ov8),
        .diff       (d8),
        .borrow     (br8),
`ifdef HA_SUB_BORROW_CNT_EN
        .borrow_cnt (cnt8),
`endif
        .borrow_any (any8)
    );

    typedef struct {
        logic       d1;
        logic       b1;
        logic [7:0] d8;
        logic [7:0] b8;
        logic [3:0] c8;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Drive one accepted vector with its hand-computed result, then advance a cycle.
    task automatic send(input logic ia1, input logic ib1, input logic ed1, input logic eb1,
                        input logic [7:0] ia8, input logic [7:0] ib8,
                        input logic [7:0] ed8, input logic [7:0] eb8, input logic [3:0] ec8);
        exp_t e;
        in_valid = 1'b1;
        a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
        e.d1 = ed1; e.b1 = eb1; e.d8 = ed8; e.b8 = eb8; e.c8 = ec8;
        if (rst_n) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_x();
        in_valid = 1'b0;
        a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(ov1 | ov8), 64'd0);
        chk({tag, "_w1"}, 64'({d1, br1, any1}), 64'd0);
        chk({tag, "_w8"}, 64'({d8, br8, any8}), 64'd0);
`ifdef HA_SUB_BORROW_CNT_EN
        chk({tag, "_cnt"}, 64'({cnt1, cnt8}), 64'd0);
`endif
    endtask

    // Monitor: pops one expectation per presented result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ov1 || ov8) begin
                chk("out_valid_agree", 64'(ov1), 64'(ov8));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no result pending");
                end else begin
                    e = exp_q.pop_front();
                    chk("diff1", 64'(d1), 64'(e.d1));
                    chk("borrow1", 64'(br1), 64'(e.b1));
                    chk("borrow_any1", 64'(any1), 64'(e.b1));
                    chk("diff8", 64'(d8), 64'(e.d8));
                    chk("borrow8", 64'(br8), 64'(e.b8));
                    chk("borrow_any8", 64'(any8), 64'(e.b8 != 8'h00));
`ifdef HA_SUB_BORROW_CNT_EN
                    chk("borrow_cnt1", 64'(cnt1), 64'(e.b1));
                    chk("borrow_cnt8", 64'(cnt8), 64'(e.c8));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two edges with an active input that must be ignored.
        rst_n = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");

        // Release reset in the same cycle the first input is presented.
        rst_n = 1'b1;
        // WIDTH=1 truth table; the 8-bit lane gets its own vectors alongside.
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCC, 8'h0C, 4'd2);
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 4'd8);
        send(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'h00, 8'h00, 4'd0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, 8'hFF, 8'hAA, 4'd4);
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 4'd0);

        // Hold: accept a vector, then idle with X on the inputs.
        send(1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 8'h7E, 8'hFF, 8'h7E, 4'd6);
        idle_x();
        chk("hold_out_valid", 64'(ov1 | ov8), 64'd0);
        chk("hold_w1", 64'({d1, br1, any1}), 64'({1'b1, 1'b0, 1'b0}));
        chk("hold_w8", 64'({d8, br8, any8}), 64'({8'hFF, 8'h7E, 1'b1}));
`ifdef HA_SUB_BORROW_CNT_EN
        chk("hold_cnt8", 64'(cnt8), 64'd6);
`endif
        idle_x();
        chk("hold2_w8", 64'({d8, br8}), 64'({8'hFF, 8'h7E}));

        // Mid-stream reset during back-to-back valid inputs.
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'hFF, 8'hF0, 4'd4);
        send(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h0F, 8'h33, 8'h03, 4'd2);
        rst_n = 1'b0;
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 4'd8);
        chk_zero("midreset");
        rst_n = 1'b1;
        send(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h03, 8'h02, 8'h02, 4'd1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCC, 8'h0C, 4'd2);
        idle_x();
        idle_x();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
